tlb_cmd_unit: RTL and testbench
===============================

Name: tlb_cmd_unit

Overview:
- Initiator-side controller for the TLB array. It executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB commands issued by the pipeline.
- It drives the array's search-port-1, read, write and invtlb ports, and returns CSR write-back values (TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID) through a valid/ready result channel.
- It sits between the EX/WB CSR logic and the TLB array, and owns the fill-index policy.

Parameters:
- TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  unit can accept a command.
- cmd_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 are illegal.
- cmd_invop  in  5  INVTLB op field.
- cmd_inv_asid  in  10  INVTLB rj ASID.
- cmd_inv_vppn  in  19  INVTLB rk VA[31:13].
- csr_asid  in  10  ASID.ASID.
- csr_ehi_vppn  in  19  TLBEHI.VPPN.
- csr_idx_index  in  IW  TLBIDX.Index.
- csr_idx_ps  in  6  TLBIDX.PS.
- csr_idx_ne  in  1  TLBIDX.NE.
- csr_elo0, csr_elo1  in  27  {ppn[19:0], g, mat[1:0], plv[1:0], d, v}.
- csr_in_tlbr  in  1  ESTAT.Ecode == TLBR (0x3F).
- tlb_s1_sel  out  1  unit owns search port 1 this cycle.
- tlb_s1_vppn/tlb_s1_asid/tlb_s1_va_bit12  out  19/10/1  search-port-1 request.
- tlb_s1_found/tlb_s1_index  in  1/IW  search result.
- tlb_invtlb_valid/tlb_invtlb_op  out  1/5  invalidate request.
- tlb_we  out  1  write enable.
- tlb_w_index  out  IW  write index.
- tlb_w_e/w_vppn/w_ps/w_asid/w_g  out  1/19/6/10/1  write entry fields.
- tlb_w_ppn0/plv0/mat0/d0/v0  out  20/2/2/1/1  even-page fields.
- tlb_w_ppn1/plv1/mat1/d1/v1  out  20/2/2/1/1  odd-page fields.
- tlb_r_index  out  IW  read index.
- tlb_r_e/r_vppn/r_ps/r_asid/r_g  in  1/19/6/10/1  read entry fields.
- tlb_r_ppn0..v0 and tlb_r_ppn1..v1  in  same widths as the write fields.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_op  out  3  echo of the command op.
- res_err  out  1  illegal op or invop (INE).
- res_we_idx/res_we_ehi/res_we_elo/res_we_asid  out  1 each  CSR write strobes, qualified by res_valid.
- res_ne/res_index/res_ps  out  1/IW/6  TLBIDX values.
- res_vppn  out  19  TLBEHI value.
- res_elo0/res_elo1  out  27  TLBELO values.
- res_asid  out  10  ASID value.

Behaviour:
- FSM states are IDLE, EXEC, RESP. Reset (async) forces IDLE and zeroes the fill pointer, all res_* outputs and every tlb_* output. Reset mid-command aborts it; no write or invalidate is issued after reset asserts.
- IDLE: cmd_ready=1. When cmd_valid=1, latch op, invop, inv_asid, inv_vppn and all csr_* inputs, then go to EXEC. CSR inputs are sampled only at acceptance.
- EXEC lasts exactly one cycle. tlb_we and tlb_invtlb_valid are combinational decodes of EXEC plus the latched op, so each is high for that single cycle only. Array results (combinational) are captured at the end of EXEC. Next state is RESP.
- SRCH:
  - tlb_s1_sel=1, s1_vppn=latched ehi_vppn, s1_asid=latched asid, va_bit12=0.
  - found: res_ne=0, res_index=s1_index.
  - not found: res_ne=1, res_index=latched idx_index.
  - Only res_we_idx=1.
- RD:
  - r_index=latched idx_index.
  - r_e=1: res_ne=0, res_ps=r_ps, res_vppn=r_vppn, res_asid=r_asid. Each elo is {ppn, g=r_g, mat, plv, d, v}.
  - r_e=0: res_ne=1, and res_ps, res_vppn, res_elo0, res_elo1, res_asid are all 0.
  - Strobes idx/ehi/elo/asid are all 1.
- WR/FILL:
  - tlb_we=1; w_index is latched idx_index for WR and fill_ptr for FILL.
  - w_e = csr_in_tlbr ? 1 : ~idx_ne.
  - w_vppn = ehi_vppn, w_ps = idx_ps, w_asid = asid, w_g = elo0.g & elo1.g.
  - Per-page fields come from elo0/elo1.
  - No CSR strobes are raised.
  - FILL advances fill_ptr by 1 at the end of EXEC, wrapping from TLBNUM-1 to 0. WR never changes fill_ptr.
- INV:
  - invop 0..6: tlb_invtlb_valid=1, invtlb_op=invop, tlb_s1_sel=1, s1_asid=inv_asid, s1_vppn=inv_vppn.
  - invop >6: no invalidate, res_err=1.
  - No CSR strobes are raised.
- cmd_op 5-7: no TLB port activity, res_err=1.
- RESP: res_valid=1, cmd_ready=0, and res_* are held stable.
  - res_ready=1 returns the FSM to IDLE; res_valid drops the next cycle.
  - Throughput is one command per 3 cycles with no stall.
  - cmd_valid is ignored outside IDLE.
- tlb_w_* and tlb_r_index are zero outside EXEC. tlb_s1_* are zero whenever tlb_s1_sel=0.

Test Plan:
- After reset, write entry 3 with vppn=0x12345 and asid=0x5, then SRCH with ehi_vppn=0x12345, asid=0x5 -> res_ne=0, res_index=3, res_we_idx=1, 3 cycles to res_valid.
- SRCH on a miss with idx_index=7 -> res_ne=1, res_index=7.
- RD of an invalid entry with idx_index=2 -> res_ne=1, res_vppn=0, res_asid=0, res_elo0=0, res_elo1=0, all four strobes=1.
- Issue 17 FILLs with TLBNUM=16 -> w_index sequence 0,1,…,15,0. WR between fills leaves fill_ptr unchanged. With csr_in_tlbr=1 and idx_ne=1, w_e=1.
- INV with invop=5, asid=0x7, vppn=0x00100 -> invtlb_valid high for exactly 1 cycle with op=5. invop=9 -> invtlb_valid stays 0, res_err=1.
- Hold res_ready=0 for 4 cycles -> res_* stable, cmd_ready=0. Assert reset during EXEC of a WR -> tlb_we drops immediately, state is IDLE, fill_ptr=0.

Source files
------------

// File: rtl/tlb_cmd_unit.sv
// TLB command controller: runs TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the
// TLB array and hands CSR write-back values to the pipeline over a valid/ready channel.
module tlb_cmd_unit #(
    parameter int  TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [4:0]    cmd_invop,
    input  logic [9:0]    cmd_inv_asid,
    input  logic [18:0]   cmd_inv_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [18:0]   csr_ehi_vppn,
    input  logic [IW-1:0] csr_idx_index,
    input  logic [5:0]    csr_idx_ps,
    input  logic          csr_idx_ne,
    input  logic [26:0]   csr_elo0,
    input  logic [26:0]   csr_elo1,
    input  logic          csr_in_tlbr,
    output logic          tlb_s1_sel,
    output logic [18:0]   tlb_s1_vppn,
    output logic [9:0]    tlb_s1_asid,
    output logic          tlb_s1_va_bit12,
    input  logic          tlb_s1_found,
    input  logic [IW-1:0] tlb_s1_index,
    output logic          tlb_invtlb_valid,
    output logic [4:0]    tlb_invtlb_op,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic          tlb_w_e,
    output logic [18:0]   tlb_w_vppn,
    output logic [5:0]    tlb_w_ps,
    output logic [9:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [19:0]   tlb_w_ppn0,
    output logic [1:0]    tlb_w_plv0,
    output logic [1:0]    tlb_w_mat0,
    output logic          tlb_w_d0,
    output logic          tlb_w_v0,
    output logic [19:0]   tlb_w_ppn1,
    output logic [1:0]    tlb_w_plv1,
    output logic [1:0]    tlb_w_mat1,
    output logic          tlb_w_d1,
    output logic          tlb_w_v1,
    output logic [IW-1:0] tlb_r_index,
    input  logic          tlb_r_e,
    input  logic [18:0]   tlb_r_vppn,
    input  logic [5:0]    tlb_r_ps,
    input  logic [9:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [19:0]   tlb_r_ppn0,
    input  logic [1:0]    tlb_r_plv0,
    input  logic [1:0]    tlb_r_mat0,
    input  logic          tlb_r_d0,
    input  logic          tlb_r_v0,
    input  logic [19:0]   tlb_r_ppn1,
    input  logic [1:0]    tlb_r_plv1,
    input  logic [1:0]    tlb_r_mat1,
    input  logic          tlb_r_d1,
    input  logic          tlb_r_v1,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [2:0]    res_op,
    output logic          res_err,
    output logic          res_we_idx,
    output logic          res_we_ehi,
    output logic          res_we_elo,
    output logic          res_we_asid,
    output logic          res_ne,
    output logic [IW-1:0] res_index,
    output logic [5:0]    res_ps,
    output logic [18:0]   res_vppn,
    output logic [26:0]   res_elo0,
    output logic [26:0]   res_elo1,
    output logic [9:0]    res_asid
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] fill_ptr_q, fill_ptr_d;

    logic [2:0]    op_q;
    logic [4:0]    invop_q;
    logic [9:0]    inv_asid_q, asid_q;
    logic [18:0]   inv_vppn_q, ehi_vppn_q;
    logic [IW-1:0] idx_index_q;
    logic [5:0]    idx_ps_q;
    logic          idx_ne_q, in_tlbr_q;
    logic [26:0]   elo0_q, elo1_q;

    logic [2:0]    res_op_q, res_op_d;
    logic          res_err_q, res_err_d;
    logic [3:0]    res_we_q, res_we_d;
    logic          res_ne_q, res_ne_d;
    logic [IW-1:0] res_index_q, res_index_d;
    logic [5:0]    res_ps_q, res_ps_d;
    logic [18:0]   res_vppn_q, res_vppn_d;
    logic [26:0]   res_elo0_q, res_elo0_d, res_elo1_q, res_elo1_d;
    logic [9:0]    res_asid_q, res_asid_d;

    logic exec, is_srch, is_rd, is_wr, is_fill, is_inv, inv_ok, illegal;

    assign exec    = (state_q == EXEC);
    assign is_srch = (op_q == 3'd0);
    assign is_rd   = (op_q == 3'd1);
    assign is_wr   = (op_q == 3'd2);
    assign is_fill = (op_q == 3'd3);
    assign is_inv  = (op_q == 3'd4);
    assign illegal = (op_q > 3'd4);
    assign inv_ok  = (invop_q <= 5'd6);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fill_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_ptr_q <= fill_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_ptr_d = fill_ptr_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = EXEC;
            EXEC: begin
                state_d = RESP;
                if (is_fill)
                    fill_ptr_d = (fill_ptr_q == IW'(TLBNUM - 1)) ? '0 : fill_ptr_q + 1'b1;
            end
            RESP: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command fields and CSR snapshot are taken only at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0; invop_q <= '0; inv_asid_q <= '0; inv_vppn_q <= '0;
            asid_q <= '0; ehi_vppn_q <= '0; idx_index_q <= '0; idx_ps_q <= '0;
            idx_ne_q <= 1'b0; in_tlbr_q <= 1'b0; elo0_q <= '0; elo1_q <= '0;
        end else if (state_q == IDLE && cmd_valid) begin
            op_q <= cmd_op; invop_q <= cmd_invop;
            inv_asid_q <= cmd_inv_asid; inv_vppn_q <= cmd_inv_vppn;
            asid_q <= csr_asid; ehi_vppn_q <= csr_ehi_vppn;
            idx_index_q <= csr_idx_index; idx_ps_q <= csr_idx_ps;
            idx_ne_q <= csr_idx_ne; in_tlbr_q <= csr_in_tlbr;
            elo0_q <= csr_elo0; elo1_q <= csr_elo1;
        end
    end

    assign cmd_ready        = (state_q == IDLE);
    assign tlb_we           = exec & (is_wr | is_fill);
    assign tlb_invtlb_valid = exec & is_inv & inv_ok;
    assign tlb_invtlb_op    = tlb_invtlb_valid ? invop_q : '0;
    assign tlb_s1_sel       = exec & (is_srch | (is_inv & inv_ok));
    assign tlb_s1_vppn      = !tlb_s1_sel ? '0 : (is_inv ? inv_vppn_q : ehi_vppn_q);
    assign tlb_s1_asid      = !tlb_s1_sel ? '0 : (is_inv ? inv_asid_q : asid_q);
    assign tlb_s1_va_bit12  = 1'b0;
    assign tlb_r_index      = (exec & is_rd) ? idx_index_q : '0;

    // ELO layout: {ppn[26:7], g[6], mat[5:4], plv[3:2], d[1], v[0]}.
    assign tlb_w_index = !tlb_we ? '0 : (is_fill ? fill_ptr_q : idx_index_q);
    assign tlb_w_e     = tlb_we & (in_tlbr_q | ~idx_ne_q);
    assign tlb_w_vppn  = tlb_we ? ehi_vppn_q : '0;
    assign tlb_w_ps    = tlb_we ? idx_ps_q   : '0;
    assign tlb_w_asid  = tlb_we ? asid_q     : '0;
    assign tlb_w_g     = tlb_we & elo0_q[6] & elo1_q[6];
    assign tlb_w_ppn0  = tlb_we ? elo0_q[26:7] : '0;
    assign tlb_w_mat0  = tlb_we ? elo0_q[5:4]  : '0;
    assign tlb_w_plv0  = tlb_we ? elo0_q[3:2]  : '0;
    assign tlb_w_d0    = tlb_we & elo0_q[1];
    assign tlb_w_v0    = tlb_we & elo0_q[0];
    assign tlb_w_ppn1  = tlb_we ? elo1_q[26:7] : '0;
    assign tlb_w_mat1  = tlb_we ? elo1_q[5:4]  : '0;
    assign tlb_w_plv1  = tlb_we ? elo1_q[3:2]  : '0;
    assign tlb_w_d1    = tlb_we & elo1_q[1];
    assign tlb_w_v1    = tlb_we & elo1_q[0];

    always_comb begin
        res_op_d    = op_q;
        res_err_d   = illegal | (is_inv & ~inv_ok);
        res_we_d    = 4'b0000;
        res_ne_d    = 1'b0;
        res_index_d = idx_index_q;
        res_ps_d    = '0;
        res_vppn_d  = '0;
        res_elo0_d  = '0;
        res_elo1_d  = '0;
        res_asid_d  = '0;
        if (is_srch) begin
            res_we_d    = 4'b1000;
            res_ne_d    = ~tlb_s1_found;
            res_index_d = tlb_s1_found ? tlb_s1_index : idx_index_q;
            res_ps_d    = idx_ps_q;
        end else if (is_rd) begin
            res_we_d = 4'b1111;
            res_ne_d = ~tlb_r_e;
            if (tlb_r_e) begin
                res_ps_d   = tlb_r_ps;
                res_vppn_d = tlb_r_vppn;
                res_asid_d = tlb_r_asid;
                res_elo0_d = {tlb_r_ppn0, tlb_r_g, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0};
                res_elo1_d = {tlb_r_ppn1, tlb_r_g, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_op_q <= '0; res_err_q <= 1'b0; res_we_q <= '0; res_ne_q <= 1'b0;
            res_index_q <= '0; res_ps_q <= '0; res_vppn_q <= '0;
            res_elo0_q <= '0; res_elo1_q <= '0; res_asid_q <= '0;
        end else if (exec) begin
            res_op_q <= res_op_d; res_err_q <= res_err_d; res_we_q <= res_we_d;
            res_ne_q <= res_ne_d; res_index_q <= res_index_d; res_ps_q <= res_ps_d;
            res_vppn_q <= res_vppn_d; res_elo0_q <= res_elo0_d;
            res_elo1_q <= res_elo1_d; res_asid_q <= res_asid_d;
        end
    end

    assign res_valid   = (state_q == RESP);
    assign res_op      = res_op_q;
    assign res_err     = res_err_q;
    assign res_we_idx  = res_valid & res_we_q[3];
    assign res_we_ehi  = res_valid & res_we_q[2];
    assign res_we_elo  = res_valid & res_we_q[1];
    assign res_we_asid = res_valid & res_we_q[0];
    assign res_ne      = res_ne_q;
    assign res_index   = res_index_q;
    assign res_ps      = res_ps_q;
    assign res_vppn    = res_vppn_q;
    assign res_elo0    = res_elo0_q;
    assign res_elo1    = res_elo1_q;
    assign res_asid    = res_asid_q;
endmodule

// File: tb/tb_tlb_cmd_unit.sv
// Bench for tlb_cmd_unit: a behavioural 16-entry TLB array, a result scoreboard
// and per-feature scenario tasks.
module tb_tlb_cmd_unit;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic cmd_valid = 0, cmd_ready, res_valid, res_ready = 0;
    logic [2:0] cmd_op = 0, res_op;
    logic [4:0] cmd_invop = 0, tlb_invtlb_op;
    logic [9:0] cmd_inv_asid = 0, csr_asid = 0, tlb_s1_asid, tlb_w_asid, tlb_r_asid, res_asid;
    logic [18:0] cmd_inv_vppn = 0, csr_ehi_vppn = 0, tlb_s1_vppn, tlb_w_vppn, tlb_r_vppn, res_vppn;
    logic [3:0] csr_idx_index = 0, tlb_s1_index, tlb_w_index, tlb_r_index, res_index;
    logic [5:0] csr_idx_ps = 0, tlb_w_ps, tlb_r_ps, res_ps;
    logic csr_idx_ne = 0, csr_in_tlbr = 0;
    logic [26:0] csr_elo0 = 0, csr_elo1 = 0, res_elo0, res_elo1;
    logic tlb_s1_sel, tlb_s1_va_bit12, tlb_s1_found, tlb_invtlb_valid, tlb_we;
    logic tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic [19:0] tlb_w_ppn0, tlb_w_ppn1, tlb_r_ppn0, tlb_r_ppn1;
    logic [1:0] tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
    logic [1:0] tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
    logic tlb_r_e, tlb_r_g, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
    logic res_err, res_we_idx, res_we_ehi, res_we_elo, res_we_asid, res_ne;

    tlb_cmd_unit #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_invop(cmd_invop), .cmd_inv_asid(cmd_inv_asid),
        .cmd_inv_vppn(cmd_inv_vppn), .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn),
        .csr_idx_index(csr_idx_index), .csr_idx_ps(csr_idx_ps), .csr_idx_ne(csr_idx_ne),
        .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_in_tlbr(csr_in_tlbr),
        .tlb_s1_sel(tlb_s1_sel), .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid),
        .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_found(tlb_s1_found),
        .tlb_s1_index(tlb_s1_index), .tlb_invtlb_valid(tlb_invtlb_valid),
        .tlb_invtlb_op(tlb_invtlb_op), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps),
        .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g), .tlb_w_ppn0(tlb_w_ppn0),
        .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0), .tlb_w_d0(tlb_w_d0),
        .tlb_w_v0(tlb_w_v0), .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1),
        .tlb_w_mat1(tlb_w_mat1), .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
        .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
        .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
        .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0), .tlb_r_ppn1(tlb_r_ppn1),
        .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1), .tlb_r_d1(tlb_r_d1),
        .tlb_r_v1(tlb_r_v1), .res_valid(res_valid), .res_ready(res_ready),
        .res_op(res_op), .res_err(res_err), .res_we_idx(res_we_idx),
        .res_we_ehi(res_we_ehi), .res_we_elo(res_we_elo), .res_we_asid(res_we_asid),
        .res_ne(res_ne), .res_index(res_index), .res_ps(res_ps), .res_vppn(res_vppn),
        .res_elo0(res_elo0), .res_elo1(res_elo1), .res_asid(res_asid)
    );

    // Behavioural TLB array
    typedef struct packed {
        logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
        logic [19:0] ppn0; logic [1:0] plv0, mat0; logic d0, v0;
        logic [19:0] ppn1; logic [1:0] plv1, mat1; logic d1, v1;
    } ent_t;
    ent_t mem [16];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (tlb_we) begin
            mem[tlb_w_index] <= '{tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                                  tlb_w_ppn0, tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0,
                                  tlb_w_ppn1, tlb_w_plv1, tlb_w_mat1, tlb_w_d1, tlb_w_v1};
        end
    end

    always_comb begin
        tlb_s1_found = 1'b0;
        tlb_s1_index = '0;
        for (int i = 0; i < 16; i++)
            if (mem[i].e && mem[i].vppn == tlb_s1_vppn && (mem[i].g || mem[i].asid == tlb_s1_asid)) begin
                tlb_s1_found = 1'b1;
                tlb_s1_index = 4'(i);
            end
    end

    assign {tlb_r_e, tlb_r_vppn, tlb_r_ps, tlb_r_asid, tlb_r_g,
            tlb_r_ppn0, tlb_r_plv0, tlb_r_mat0, tlb_r_d0, tlb_r_v0,
            tlb_r_ppn1, tlb_r_plv1, tlb_r_mat1, tlb_r_d1, tlb_r_v1} = mem[tlb_r_index];

    // Scoreboard
    typedef struct packed {
        logic [2:0] op; logic err; logic [3:0] we; logic ne; logic chk_idx;
        logic [3:0] index; logic [5:0] ps; logic [18:0] vppn; logic [9:0] asid;
        logic [26:0] elo0, elo1;
    } exp_t;
    exp_t sb [$];
    int vectors = 0, miscompares = 0, inv_cnt = 0, last_lat = 0;

    function automatic exp_t mk(input logic [2:0] op, input logic err, input logic [3:0] we,
                                input logic ne, input logic chk_idx, input logic [3:0] index);
        exp_t e = '0;
        e.op = op; e.err = err; e.we = we; e.ne = ne; e.chk_idx = chk_idx; e.index = index;
        return e;
    endfunction

    always @(negedge clk) if (tlb_invtlb_valid) inv_cnt++;

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: result op=%0d with empty scoreboard", res_op);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (res_op !== e.op || res_err !== e.err ||
                    {res_we_idx, res_we_ehi, res_we_elo, res_we_asid} !== e.we) begin
                    miscompares++;
                    $display("FAIL res_ctrl: op=%0d err=%b we=%b, expected op=%0d err=%b we=%b",
                             res_op, res_err, {res_we_idx, res_we_ehi, res_we_elo, res_we_asid},
                             e.op, e.err, e.we);
                end
                if (e.we[3] && res_ne !== e.ne) begin
                    miscompares++;
                    $display("FAIL res_ne: got %b expected %b (op %0d)", res_ne, e.ne, e.op);
                end
                if (e.chk_idx && res_index !== e.index) begin
                    miscompares++;
                    $display("FAIL res_index: got %0d expected %0d", res_index, e.index);
                end
                if (e.op == 3'd1 && {res_ps, res_vppn, res_asid, res_elo0, res_elo1} !==
                                    {e.ps, e.vppn, e.asid, e.elo0, e.elo1}) begin
                    miscompares++;
                    $display("FAIL rd_data: ps=%h vppn=%h asid=%h elo0=%h elo1=%h exp ps=%h vppn=%h asid=%h elo0=%h elo1=%h",
                             res_ps, res_vppn, res_asid, res_elo0, res_elo1,
                             e.ps, e.vppn, e.asid, e.elo0, e.elo1);
                end
            end
        end
    end

    // Snapshot of the array ports during EXEC
    logic ex_we, ex_w_e, ex_inv, ex_s1_sel;
    logic [3:0] ex_w_index; logic [4:0] ex_inv_op;
    logic [18:0] ex_w_vppn, ex_s1_vppn; logic [9:0] ex_w_asid, ex_s1_asid;

    task automatic issue_cmd(input logic [2:0] op, input logic [4:0] invop, input exp_t e);
        int n;
        sb.push_back(e);
        cmd_op = op; cmd_invop = invop; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        {ex_we, ex_w_e, ex_w_index, ex_w_vppn, ex_w_asid} = {tlb_we, tlb_w_e, tlb_w_index, tlb_w_vppn, tlb_w_asid};
        {ex_inv, ex_inv_op, ex_s1_sel, ex_s1_vppn, ex_s1_asid} =
            {tlb_invtlb_valid, tlb_invtlb_op, tlb_s1_sel, tlb_s1_vppn, tlb_s1_asid};
        // CSR inputs must only matter at acceptance
        csr_ehi_vppn = 19'h7_FFFF; csr_asid = 10'h3FF; csr_idx_index = 4'hF; csr_elo0 = '1;
        n = 1;
        while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
        last_lat = n;
        if (!res_valid) begin
            vectors++; miscompares++;
            void'(sb.pop_back());
            $display("FAIL res_timeout: res_valid=%b after %0d cycles, expected 1", res_valid, n);
        end
    endtask

    task automatic retire_cmd();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1 || res_valid !== 0 || tlb_we !== 0 || tlb_s1_sel !== 0 ||
            tlb_invtlb_valid !== 0 || res_index !== 0 || res_vppn !== 0 || res_err !== 0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b vld=%b we=%b sel=%b inv=%b idx=%0d vppn=%h err=%b",
                     cmd_ready, res_valid, tlb_we, tlb_s1_sel, tlb_invtlb_valid, res_index, res_vppn, res_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wr_srch_rd();
        exp_t e;
        logic [26:0] elo0, elo1;
        elo0 = {20'h00AB1, 1'b0, 2'b01, 2'b11, 1'b1, 1'b1};
        elo1 = {20'h00AB2, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1};
        csr_idx_index = 4'd3; csr_ehi_vppn = 19'h12345; csr_asid = 10'h5; csr_idx_ps = 6'd12;
        csr_idx_ne = 0; csr_in_tlbr = 0; csr_elo0 = elo0; csr_elo1 = elo1;
        issue_cmd(3'd2, 5'd0, mk(3'd2, 0, 4'b0000, 0, 0, 0));
        vectors++;
        if (ex_we !== 1 || ex_w_index !== 4'd3 || ex_w_e !== 1 || ex_w_vppn !== 19'h12345 || ex_w_asid !== 10'h5) begin
            miscompares++;
            $display("FAIL wr_port: we=%b idx=%0d e=%b vppn=%h asid=%h, expected 1/3/1/12345/5",
                     ex_we, ex_w_index, ex_w_e, ex_w_vppn, ex_w_asid);
        end
        retire_cmd();
        // hit
        csr_ehi_vppn = 19'h12345; csr_asid = 10'h5; csr_idx_index = 4'd9;
        issue_cmd(3'd0, 5'd0, mk(3'd0, 0, 4'b1000, 0, 1, 4'd3));
        vectors++;
        if (last_lat !== 2 || ex_s1_sel !== 1 || ex_s1_vppn !== 19'h12345 || ex_s1_asid !== 10'h5) begin
            miscompares++;
            $display("FAIL srch_hit: latency=%0d sel=%b vppn=%h asid=%h, expected 2/1/12345/5",
                     last_lat, ex_s1_sel, ex_s1_vppn, ex_s1_asid);
        end
        retire_cmd();
        // miss
        csr_ehi_vppn = 19'h54321; csr_asid = 10'h5; csr_idx_index = 4'd7;
        issue_cmd(3'd0, 5'd0, mk(3'd0, 0, 4'b1000, 1, 1, 4'd7));
        retire_cmd();
        // RD of an invalid entry
        csr_idx_index = 4'd2;
        issue_cmd(3'd1, 5'd0, mk(3'd1, 0, 4'b1111, 1, 0, 0));
        retire_cmd();
        // RD of the entry written above
        e = mk(3'd1, 0, 4'b1111, 0, 0, 0);
        e.ps = 6'd12; e.vppn = 19'h12345; e.asid = 10'h5;
        e.elo0 = {20'h00AB1, 1'b0, 2'b01, 2'b11, 1'b1, 1'b1};
        e.elo1 = {20'h00AB2, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1};
        csr_idx_index = 4'd3;
        issue_cmd(3'd1, 5'd0, e);
        retire_cmd();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            csr_idx_index = 4'hA; csr_ehi_vppn = 19'h70000 + 19'(i); csr_asid = 10'h1;
            csr_idx_ne = 1'b1; csr_in_tlbr = i[0]; csr_elo0 = 27'h1; csr_elo1 = 27'h1;
            issue_cmd(3'd3, 5'd0, mk(3'd3, 0, 4'b0000, 0, 0, 0));
            vectors++;
            if (ex_we !== 1 || ex_w_index !== 4'(i % 16) || ex_w_e !== i[0]) begin
                miscompares++;
                $display("FAIL fill_%0d: we=%b idx=%0d e=%b, expected 1/%0d/%b",
                         i, ex_we, ex_w_index, ex_w_e, i % 16, i[0]);
            end
            retire_cmd();
            if (i == 5) begin
                csr_idx_index = 4'd12; csr_idx_ne = 1'b0; csr_in_tlbr = 1'b0;
                issue_cmd(3'd2, 5'd0, mk(3'd2, 0, 4'b0000, 0, 0, 0));
                vectors++;
                if (ex_w_index !== 4'd12 || ex_w_e !== 1) begin
                    miscompares++;
                    $display("FAIL wr_between_fills: idx=%0d e=%b, expected 12/1", ex_w_index, ex_w_e);
                end
                retire_cmd();
            end
        end
    endtask

    task automatic test_inv();
        int c0;
        cmd_inv_asid = 10'h7; cmd_inv_vppn = 19'h00100;
        c0 = inv_cnt;
        issue_cmd(3'd4, 5'd5, mk(3'd4, 0, 4'b0000, 0, 0, 0));
        retire_cmd();
        vectors++;
        if (ex_inv !== 1 || ex_inv_op !== 5'd5 || inv_cnt - c0 !== 1 || ex_s1_sel !== 1 ||
            ex_s1_asid !== 10'h7 || ex_s1_vppn !== 19'h00100) begin
            miscompares++;
            $display("FAIL inv_op5: valid=%b op=%0d cycles=%0d sel=%b asid=%h vppn=%h, expected 1/5/1/1/7/00100",
                     ex_inv, ex_inv_op, inv_cnt - c0, ex_s1_sel, ex_s1_asid, ex_s1_vppn);
        end
        c0 = inv_cnt;
        issue_cmd(3'd4, 5'd9, mk(3'd4, 1, 4'b0000, 0, 0, 0));
        retire_cmd();
        vectors++;
        if (inv_cnt - c0 !== 0 || ex_s1_sel !== 0) begin
            miscompares++;
            $display("FAIL inv_op9: invalidate cycles=%0d sel=%b, expected 0/0", inv_cnt - c0, ex_s1_sel);
        end
        c0 = inv_cnt;
        issue_cmd(3'd6, 5'd2, mk(3'd6, 1, 4'b0000, 0, 0, 0));
        retire_cmd();
        vectors++;
        if (ex_we !== 0 || ex_s1_sel !== 0 || inv_cnt - c0 !== 0) begin
            miscompares++;
            $display("FAIL illegal_op: we=%b sel=%b inv cycles=%0d, expected 0/0/0", ex_we, ex_s1_sel, inv_cnt - c0);
        end
    endtask

    task automatic test_hold();
        csr_ehi_vppn = 19'h0BEEF; csr_asid = 10'h2; csr_idx_index = 4'd5;
        issue_cmd(3'd0, 5'd0, mk(3'd0, 0, 4'b1000, 1, 1, 4'd5));
        cmd_valid = 1'b1; cmd_op = 3'd2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (res_valid !== 1 || cmd_ready !== 0 || res_index !== 4'd5 || res_ne !== 1 ||
                res_we_idx !== 1 || tlb_we !== 0) begin
                miscompares++;
                $display("FAIL hold_%0d: vld=%b rdy=%b idx=%0d ne=%b we_idx=%b tlb_we=%b, expected 1/0/5/1/1/0",
                         k, res_valid, cmd_ready, res_index, res_ne, res_we_idx, tlb_we);
            end
        end
        cmd_valid = 1'b0;
        retire_cmd();
        vectors++;
        if (res_valid !== 0 || cmd_ready !== 1) begin
            miscompares++;
            $display("FAIL hold_release: vld=%b rdy=%b, expected 0/1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_wr();
        csr_idx_index = 4'd6; csr_idx_ne = 1'b0; csr_ehi_vppn = 19'h00AAA;
        cmd_op = 3'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        vectors++;
        if (tlb_we !== 1) begin
            miscompares++;
            $display("FAIL rst_mid_exec: tlb_we=%b, expected 1", tlb_we);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (tlb_we !== 0 || cmd_ready !== 1 || res_valid !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_abort: tlb_we=%b rdy=%b vld=%b, expected 0/1/0", tlb_we, cmd_ready, res_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        csr_idx_index = 4'd9; csr_idx_ne = 1'b0; csr_in_tlbr = 1'b0;
        issue_cmd(3'd3, 5'd0, mk(3'd3, 0, 4'b0000, 0, 0, 0));
        vectors++;
        if (ex_w_index !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_fill_ptr: w_index=%0d, expected 0", ex_w_index);
        end
        retire_cmd();
    endtask

    initial begin
        test_reset();
        test_wr_srch_rd();
        test_fill();
        test_inv();
        test_hold();
        test_reset_mid_wr();
        repeat (2) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
